viterbi_input_pacer: RTL and testbench

VITERBI_INPUT_PACER -- requirements
Module: viterbi_input_pacer

---
 rtl/viterbi_pkg.sv | 24 ++
 rtl/llr_fifo.sv | 55 +++++
 rtl/viterbi_input_pacer.sv | 92 +++++++++
 tb/tb_viterbi_input_pacer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared widths, erasure constant and LLR quantizer
package viterbi_pkg;

  localparam int SOFT_W = 4;
  localparam int LLR_W  = 6;

  localparam logic [SOFT_W-1:0]       ERASURE_VAL   = 4'd8;
  localparam logic signed [LLR_W-1:0] LLR_CLAMP_MIN = -6'sd8;
  localparam logic signed [LLR_W-1:0] LLR_CLAMP_MAX = 6'sd7;

  // Clamp to the 4-bit signed range, then offset so -8 maps to 0 and +7 to 15.
  function automatic logic [SOFT_W-1:0] quantize(input logic signed [LLR_W-1:0] llr);
    logic signed [LLR_W-1:0] clamped;
    if (llr < LLR_CLAMP_MIN) begin
      clamped = LLR_CLAMP_MIN;
    end else if (llr > LLR_CLAMP_MAX) begin
      clamped = LLR_CLAMP_MAX;
    end else begin
      clamped = llr;
    end
    return SOFT_W'(clamped - LLR_CLAMP_MIN);
  endfunction

endpackage

// File: rtl/llr_fifo.sv
// rtl/llr_fifo.sv - synchronous FIFO of quantized symbol triples
module llr_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/viterbi_input_pacer.sv
// rtl/viterbi_input_pacer.sv - buffers soft triples and releases one per PERIOD cycles
module viterbi_input_pacer
  import viterbi_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PERIOD = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable_in,
  input  logic                     llr_valid_in,
  input  logic signed [LLR_W-1:0]  llr0_in,
  input  logic signed [LLR_W-1:0]  llr1_in,
  input  logic signed [LLR_W-1:0]  llr2_in,
  output logic                     llr_ready_out,
  output logic [SOFT_W-1:0]        yn_out0,
  output logic [SOFT_W-1:0]        yn_out1,
  output logic [SOFT_W-1:0]        yn_out2,
  output logic                     sym_strobe_out,
  output logic                     erasure_out,
  output logic                     overflow_out,
  output logic [7:0]               underflow_cnt_out
);

  localparam int PW = $clog2(PERIOD);

  logic [PW-1:0]         phase;
  logic                  pacing;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [3*SOFT_W-1:0]   push_data;
  logic [3*SOFT_W-1:0]   pop_data;

  assign pacing        = enable_in && (phase == PW'(PERIOD - 1));
  assign llr_ready_out = !fifo_full;
  assign push          = llr_valid_in && !fifo_full;
  assign pop           = pacing && !fifo_empty;
  assign push_data     = {quantize(llr2_in), quantize(llr1_in), quantize(llr0_in)};

  llr_fifo #(
    .WIDTH (3 * SOFT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An empty FIFO at a pacing edge produces a neutral erasure symbol.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase             <= '0;
      yn_out0           <= ERASURE_VAL;
      yn_out1           <= ERASURE_VAL;
      yn_out2           <= ERASURE_VAL;
      erasure_out       <= 1'b1;
      sym_strobe_out    <= 1'b0;
      overflow_out      <= 1'b0;
      underflow_cnt_out <= '0;
    end else begin
      phase          <= enable_in ? phase + 1'b1 : '0;
      sym_strobe_out <= pacing;
      if (llr_valid_in && fifo_full) begin
        overflow_out <= 1'b1;
      end
      if (pacing) begin
        if (!fifo_empty) begin
          yn_out0     <= pop_data[SOFT_W-1:0];
          yn_out1     <= pop_data[2*SOFT_W-1:SOFT_W];
          yn_out2     <= pop_data[3*SOFT_W-1:2*SOFT_W];
          erasure_out <= 1'b0;
        end else begin
          yn_out0     <= ERASURE_VAL;
          yn_out1     <= ERASURE_VAL;
          yn_out2     <= ERASURE_VAL;
          erasure_out <= 1'b1;
          if (underflow_cnt_out != 8'hff) begin
            underflow_cnt_out <= underflow_cnt_out + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_input_pacer.sv
// tb/tb_viterbi_input_pacer.sv - scoreboard bench for viterbi_input_pacer
module tb_viterbi_input_pacer;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable_in;
  logic              llr_valid_in;
  logic signed [5:0] llr0_in, llr1_in, llr2_in;
  logic              llr_ready_out;
  logic [3:0]        yn_out0, yn_out1, yn_out2;
  logic              sym_strobe_out, erasure_out, overflow_out;
  logic [7:0]        underflow_cnt_out;

  always #5 clk = ~clk;

  viterbi_input_pacer #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable_in         (enable_in),
    .llr_valid_in      (llr_valid_in),
    .llr0_in           (llr0_in),
    .llr1_in           (llr1_in),
    .llr2_in           (llr2_in),
    .llr_ready_out     (llr_ready_out),
    .yn_out0           (yn_out0),
    .yn_out1           (yn_out1),
    .yn_out2           (yn_out2),
    .sym_strobe_out    (sym_strobe_out),
    .erasure_out       (erasure_out),
    .overflow_out      (overflow_out),
    .underflow_cnt_out (underflow_cnt_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int          m_phase = 0;
  logic [11:0] m_q[$];
  logic [12:0] m_exp[$];
  bit          m_strobe = 0;
  bit          m_ovf = 0;
  int          m_uf = 0;

  function automatic logic [3:0] q4(input int v);
    int c;
    c = (v < -8) ? -8 : ((v > 7) ? 7 : v);
    return 4'(c + 8);
  endfunction

  task automatic tick();
    bit pace, full;
    logic [12:0] e;
    @(posedge clk);
    if (!reset_n) begin
      m_q.delete();
      m_exp.delete();
      m_phase  = 0;
      m_strobe = 0;
      m_ovf    = 0;
      m_uf     = 0;
    end else begin
      pace = enable_in && (m_phase == PERIOD - 1);
      full = (m_q.size() == DEPTH);
      if (llr_valid_in && full) m_ovf = 1;
      if (pace) begin
        if (m_q.size() != 0) begin
          e = {1'b0, m_q.pop_front()};
        end else begin
          e = 13'h1888;
          if (m_uf < 255) m_uf++;
        end
        m_exp.push_back(e);
      end
      if (llr_valid_in && !full)
        m_q.push_back({q4(int'(llr2_in)), q4(int'(llr1_in)), q4(int'(llr0_in))});
      m_phase  = enable_in ? (m_phase + 1) % PERIOD : 0;
      m_strobe = pace;
    end
    #1;
    check_eq("ready", llr_ready_out, m_q.size() < DEPTH);
    check_eq("strobe", sym_strobe_out, m_strobe);
    check_eq("overflow", overflow_out, m_ovf);
    check_eq("underflow_cnt", underflow_cnt_out, m_uf);
    if (sym_strobe_out) begin
      check_eq("sym_pending", m_exp.size() != 0, 1);
      if (m_exp.size() != 0) begin
        e = m_exp.pop_front();
        check_eq("sym", {erasure_out, yn_out2, yn_out1, yn_out0}, e);
      end
    end
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sym_strobe_out && n < limit);
    check_eq("strobe_seen", sym_strobe_out, 1);
  endtask

  task automatic push_one(input int a, input int b, input int c);
    llr0_in = 6'(a); llr1_in = 6'(b); llr2_in = 6'(c);
    llr_valid_in = 1'b1;
    tick();
    llr_valid_in = 1'b0;
  endtask

  initial begin
    int n, idx;
    logic [12:0] held;
    reset_n = 1'b0; enable_in = 1'b0; llr_valid_in = 1'b0;
    llr0_in = '0; llr1_in = '0; llr2_in = '0;
    repeat (3) tick();
    check_eq("rst_yn0", yn_out0, 8);
    check_eq("rst_yn1", yn_out1, 8);
    check_eq("rst_yn2", yn_out2, 8);
    check_eq("rst_erasure", erasure_out, 1);
    check_eq("rst_strobe", sym_strobe_out, 0);
    check_eq("rst_overflow", overflow_out, 0);
    check_eq("rst_uf", underflow_cnt_out, 0);
    reset_n = 1'b1;
    tick();
    check_eq("rst_ready", llr_ready_out, 1);

    // Idle pacing: erasure fill every PERIOD cycles, counter saturates
    enable_in = 1'b1;
    wait_strobe(20, n);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, n);
      check_eq("idle_period", n, PERIOD);
      check_eq("idle_erasure", erasure_out, 1);
      check_eq("idle_yn", {yn_out2, yn_out1, yn_out0}, 12'h888);
    end
    repeat (260) wait_strobe(20, n);
    check_eq("uf_saturated", underflow_cnt_out, 255);

    // Single triple into an empty FIFO, pushed right after a strobe
    push_one(-20, 0, 20);
    wait_strobe(20, n);
    check_eq("single_yn0", yn_out0, 0);
    check_eq("single_yn1", yn_out1, 8);
    check_eq("single_yn2", yn_out2, 15);
    check_eq("single_erasure", erasure_out, 0);

    // Fill to full with pacing frozen, then stream the rest in order
    enable_in = 1'b0;
    for (int k = 0; k < 4; k++) push_one(k, -k, 4 * k - 16);
    check_eq("full_ready", llr_ready_out, 0);
    enable_in = 1'b1;
    idx = 4;
    n = 0;
    while (idx < 8 && n < 200) begin
      llr_valid_in = llr_ready_out;
      llr0_in = 6'(idx); llr1_in = 6'(-idx); llr2_in = 6'(4 * idx - 16);
      tick();
      if (llr_valid_in) idx++;
      n++;
    end
    llr_valid_in = 1'b0;
    check_eq("stream_done", idx, 8);
    repeat (PERIOD * 6) tick();
    check_eq("no_overflow", overflow_out, 0);

    // Push while full is dropped and flagged
    enable_in = 1'b0;
    for (int k = 0; k < 4; k++) push_one(-31 + k, 31 - k, k);
    push_one(30, 30, 30);
    check_eq("overflow_set", overflow_out, 1);
    enable_in = 1'b1;
    repeat (PERIOD * 6) tick();
    check_eq("overflow_sticky", overflow_out, 1);

    // Enable gap mid-stream freezes outputs; restart takes a full period
    push_one(3, -3, 5);
    push_one(-5, 6, -7);
    wait_strobe(20, n);
    held = {erasure_out, yn_out2, yn_out1, yn_out0};
    enable_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("frozen_yn", {erasure_out, yn_out2, yn_out1, yn_out0}, held);
    end
    enable_in = 1'b1;
    wait_strobe(20, n);
    check_eq("reenable_latency", n, PERIOD);

    // Reset with entries queued discards them
    enable_in = 1'b0;
    for (int k = 0; k < 3; k++) push_one(7, 7, 7);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rst2_ready", llr_ready_out, 1);
    check_eq("rst2_erasure", erasure_out, 1);
    check_eq("rst2_yn", {yn_out2, yn_out1, yn_out0}, 12'h888);
    check_eq("rst2_uf", underflow_cnt_out, 0);
    check_eq("rst2_overflow", overflow_out, 0);
    enable_in = 1'b1;
    wait_strobe(20, n);
    check_eq("rst2_empty_fill", erasure_out, 1);
    check_eq("rst2_uf_one", underflow_cnt_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
